// File: rtl/pcie_tx_pkg.sv
// Shared types and widths for the PCIe TX arbiter slice.
package pcie_tx_pkg;

    localparam int unsigned TX_DATA_W = 64;
    localparam int unsigned TX_KEEP_W = 8;

    // Source-select encoding shared by the FSM and the datapath mux.
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_SRC1 = 2'd1;
    localparam logic [1:0] SEL_SRC2 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } tx_arb_state_t;

    // Map an arbiter state onto the mux select it implies.
    function automatic logic [1:0] state_to_sel(input tx_arb_state_t st);
        case (st)
            GNT1:    return SEL_SRC1;
            GNT2:    return SEL_SRC2;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pcie_tx_mux2.sv
// Combinational 2:1 AXI-Stream mux between the two TLP sources and the core.
module pcie_tx_mux2
    import pcie_tx_pkg::*;
(
    input  logic [1:0]           i_sel,
    input  logic                 i_core_tready,
    input  logic [TX_DATA_W-1:0] i_src1_tdata,
    input  logic [TX_KEEP_W-1:0] i_src1_tkeep,
    input  logic                 i_src1_tlast,
    input  logic                 i_src1_tvalid,
    input  logic                 i_src1_dsc,
    input  logic [TX_DATA_W-1:0] i_src2_tdata,
    input  logic [TX_KEEP_W-1:0] i_src2_tkeep,
    input  logic                 i_src2_tlast,
    input  logic                 i_src2_tvalid,
    input  logic                 i_src2_dsc,
    output logic [TX_DATA_W-1:0] o_core_tdata,
    output logic [TX_KEEP_W-1:0] o_core_tkeep,
    output logic                 o_core_tlast,
    output logic                 o_core_tvalid,
    output logic                 o_core_dsc,
    output logic                 o_src1_tready,
    output logic                 o_src2_tready
);

    logic w_is_src2;
    logic w_gnt1;
    logic w_gnt2;

    assign w_is_src2 = (i_sel == SEL_SRC2);
    assign w_gnt1    = (i_sel == SEL_SRC1);
    assign w_gnt2    = (i_sel == SEL_SRC2);

    // Payload follows sel unconditionally; only valid/ready are gated by the grant.
    always_comb begin
        o_core_tdata  = w_is_src2 ? i_src2_tdata : i_src1_tdata;
        o_core_tkeep  = w_is_src2 ? i_src2_tkeep : i_src1_tkeep;
        o_core_tlast  = w_is_src2 ? i_src2_tlast : i_src1_tlast;
        o_core_dsc    = w_is_src2 ? i_src2_dsc   : i_src1_dsc;
        o_core_tvalid = (w_gnt1 & i_src1_tvalid) | (w_gnt2 & i_src2_tvalid);
        o_src1_tready = w_gnt1 & i_core_tready;
        o_src2_tready = w_gnt2 & i_core_tready;
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-boundary round-robin arbiter sharing the PCIe core TX stream between two sources.
module pcie_tx_arbiter
    import pcie_tx_pkg::*;
#(
    parameter int unsigned GRANT_TIMEOUT = 16
)
(
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 s_axis_tx_tready,
    output logic [TX_DATA_W-1:0] s_axis_tx_tdata,
    output logic [TX_KEEP_W-1:0] s_axis_tx_tkeep,
    output logic                 s_axis_tx_tlast,
    output logic                 s_axis_tx_tvalid,
    output logic                 tx_src_dsc,
    input  logic                 s_axis_tx1_req,
    output logic                 s_axis_tx1_ack,
    output logic                 s_axis_tx1_tready,
    input  logic [TX_DATA_W-1:0] s_axis_tx1_tdata,
    input  logic [TX_KEEP_W-1:0] s_axis_tx1_tkeep,
    input  logic                 s_axis_tx1_tlast,
    input  logic                 s_axis_tx1_tvalid,
    input  logic                 tx1_src_dsc,
    input  logic                 s_axis_tx2_req,
    output logic                 s_axis_tx2_ack,
    output logic                 s_axis_tx2_tready,
    input  logic [TX_DATA_W-1:0] s_axis_tx2_tdata,
    input  logic [TX_KEEP_W-1:0] s_axis_tx2_tkeep,
    input  logic                 s_axis_tx2_tlast,
    input  logic                 s_axis_tx2_tvalid,
    input  logic                 tx2_src_dsc,
    output logic                 arb_busy
);

    // Width guarded so a disabled timeout still yields a legal 1-bit counter.
    localparam int unsigned     CNT_W  = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(GRANT_TIMEOUT);

    tx_arb_state_t    r_state;
    tx_arb_state_t    w_state_nxt;
    logic             r_last_gnt2;     // 1: source 2 was granted last
    logic             w_last_gnt2_nxt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_beat_seen;
    logic [1:0]       w_sel;
    logic             w_accept;
    logic             w_pkt_end;
    logic             w_timeout;

    assign w_sel     = state_to_sel(r_state);
    assign w_accept  = s_axis_tx_tvalid & s_axis_tx_tready;
    assign w_pkt_end = w_accept & (s_axis_tx_tlast | tx_src_dsc);
    assign w_cnt_inc = r_idle_cnt + CNT_W'(1);
    assign w_timeout = (GRANT_TIMEOUT != 0) && (r_state != IDLE) && !r_beat_seen &&
                       !w_accept && (w_cnt_inc == TO_VAL);

    assign s_axis_tx1_ack = (r_state == GNT1);
    assign s_axis_tx2_ack = (r_state == GNT2);
    assign arb_busy       = (r_state != IDLE);

    pcie_tx_mux2 u_mux (
        .i_sel         (w_sel),
        .i_core_tready (s_axis_tx_tready),
        .i_src1_tdata  (s_axis_tx1_tdata),
        .i_src1_tkeep  (s_axis_tx1_tkeep),
        .i_src1_tlast  (s_axis_tx1_tlast),
        .i_src1_tvalid (s_axis_tx1_tvalid),
        .i_src1_dsc    (tx1_src_dsc),
        .i_src2_tdata  (s_axis_tx2_tdata),
        .i_src2_tkeep  (s_axis_tx2_tkeep),
        .i_src2_tlast  (s_axis_tx2_tlast),
        .i_src2_tvalid (s_axis_tx2_tvalid),
        .i_src2_dsc    (tx2_src_dsc),
        .o_core_tdata  (s_axis_tx_tdata),
        .o_core_tkeep  (s_axis_tx_tkeep),
        .o_core_tlast  (s_axis_tx_tlast),
        .o_core_tvalid (s_axis_tx_tvalid),
        .o_core_dsc    (tx_src_dsc),
        .o_src1_tready (s_axis_tx1_tready),
        .o_src2_tready (s_axis_tx2_tready)
    );

    // Next-state: round-robin pick in IDLE, release on packet end or grant timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_gnt2_nxt = r_last_gnt2;
        case (r_state)
            IDLE: begin
                if (s_axis_tx1_req && s_axis_tx2_req) begin
                    w_state_nxt = r_last_gnt2 ? GNT1 : GNT2;
                end else if (s_axis_tx1_req) begin
                    w_state_nxt = GNT1;
                end else if (s_axis_tx2_req) begin
                    w_state_nxt = GNT2;
                end
            end
            GNT1, GNT2: begin
                if (w_pkt_end || w_timeout) begin
                    w_state_nxt     = IDLE;
                    w_last_gnt2_nxt = (r_state == GNT2);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, round-robin history and pre-first-beat wait counter.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_last_gnt2 <= 1'b1;
            r_idle_cnt  <= '0;
            r_beat_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_gnt2 <= w_last_gnt2_nxt;
            if (r_state == IDLE) begin
                r_idle_cnt  <= '0;
                r_beat_seen <= 1'b0;
            end else if (w_accept) begin
                r_beat_seen <= 1'b1;
            end else if (!r_beat_seen && (GRANT_TIMEOUT != 0)) begin
                r_idle_cnt <= w_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Randomized self-checking bench for pcie_tx_arbiter against a packet-level reference model.
module tb_pcie_tx_arbiter;
    import pcie_tx_pkg::*;

    localparam int TO     = 4;
    localparam int NCYC   = 4000;

    logic                 clk = 1'b0;
    logic                 sys_rst;
    logic                 core_rdy;
    logic [TX_DATA_W-1:0] c_tdata;
    logic [TX_KEEP_W-1:0] c_tkeep;
    logic                 c_tlast;
    logic                 c_tvalid;
    logic                 c_dsc;
    logic                 busy;

    logic                 req    [1:2];
    logic                 ack    [1:2];
    logic                 trdy   [1:2];
    logic [TX_DATA_W-1:0] tdata  [1:2];
    logic [TX_KEEP_W-1:0] tkeep  [1:2];
    logic                 tlast  [1:2];
    logic                 tvalid [1:2];
    logic                 dsc    [1:2];

    always #5 clk = ~clk;

    pcie_tx_arbiter #(.GRANT_TIMEOUT(TO)) dut (
        .clk               (clk),
        .sys_rst           (sys_rst),
        .s_axis_tx_tready  (core_rdy),
        .s_axis_tx_tdata   (c_tdata),
        .s_axis_tx_tkeep   (c_tkeep),
        .s_axis_tx_tlast   (c_tlast),
        .s_axis_tx_tvalid  (c_tvalid),
        .tx_src_dsc        (c_dsc),
        .s_axis_tx1_req    (req[1]),
        .s_axis_tx1_ack    (ack[1]),
        .s_axis_tx1_tready (trdy[1]),
        .s_axis_tx1_tdata  (tdata[1]),
        .s_axis_tx1_tkeep  (tkeep[1]),
        .s_axis_tx1_tlast  (tlast[1]),
        .s_axis_tx1_tvalid (tvalid[1]),
        .tx1_src_dsc       (dsc[1]),
        .s_axis_tx2_req    (req[2]),
        .s_axis_tx2_ack    (ack[2]),
        .s_axis_tx2_tready (trdy[2]),
        .s_axis_tx2_tdata  (tdata[2]),
        .s_axis_tx2_tkeep  (tkeep[2]),
        .s_axis_tx2_tlast  (tlast[2]),
        .s_axis_tx2_tvalid (tvalid[2]),
        .tx2_src_dsc       (dsc[2]),
        .arb_busy          (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp_v);
        end
    endtask

    // Reference model: who owns the link, who was served last, wait before first beat.
    int m_owner;
    int m_last;
    int m_wait;
    bit m_started;

    // Source-side packet bookkeeping.
    bit pend     [1:2];
    int plen     [1:2];
    int pbeat    [1:2];
    int pdsc     [1:2];
    bit pstall   [1:2];
    int pid      [1:2];
    int n_pkts_done = 0;
    int n_timeouts  = 0;

    task automatic new_pkt(input int s);
        pend[s]   = 1'b1;
        plen[s]   = $urandom_range(5, 1);
        pbeat[s]  = 0;
        pstall[s] = ($urandom % 6) == 0;
        pdsc[s]   = (($urandom % 8) == 0) ? $urandom_range(plen[s] - 1, 0) : -1;
        pid[s]++;
    endtask

    task automatic drive();
        sys_rst  = (cyc < 2) || (($urandom % 250) == 0);
        core_rdy = ($urandom % 3) != 0;
        for (int s = 1; s <= 2; s++) begin
            if (m_owner == s) begin
                // Once granted, the source may drop req freely; grant must hold.
                req[s]    = $urandom_range(1, 0);
                tvalid[s] = !pstall[s] && (($urandom % 4) != 0);
                tdata[s]  = {8'(s), 24'(pid[s]), 32'(pbeat[s])};
                tkeep[s]  = 8'($urandom);
                tlast[s]  = (pbeat[s] == plen[s] - 1);
                dsc[s]    = (pbeat[s] == pdsc[s]);
            end else begin
                if (!pend[s] && (($urandom % 4) == 0)) new_pkt(s);
                req[s]    = pend[s];
                tvalid[s] = $urandom_range(1, 0);
                tdata[s]  = {$urandom, $urandom};
                tkeep[s]  = 8'($urandom);
                tlast[s]  = $urandom_range(1, 0);
                dsc[s]    = $urandom_range(1, 0);
            end
        end
    endtask

    task automatic check_and_step();
        int  o;
        bit  exp_tv;
        bit  exp_acc;
        o       = m_owner;
        exp_tv  = (o != 0) && tvalid[o];
        exp_acc = exp_tv && core_rdy;

        chk("ack1",   64'(ack[1]),   64'(o == 1));
        chk("ack2",   64'(ack[2]),   64'(o == 2));
        chk("busy",   64'(busy),     64'(o != 0));
        chk("tvalid", 64'(c_tvalid), 64'(exp_tv));
        chk("trdy1",  64'(trdy[1]),  64'((o == 1) && core_rdy));
        chk("trdy2",  64'(trdy[2]),  64'((o == 2) && core_rdy));
        if (o != 0) begin
            chk("tdata", c_tdata,        tdata[o]);
            chk("tkeep", 64'(c_tkeep),   64'(tkeep[o]));
            chk("tlast", 64'(c_tlast),   64'(tlast[o]));
            chk("dsc",   64'(c_dsc),     64'(dsc[o]));
        end

        if (sys_rst) begin
            m_owner = 0; m_last = 2; m_wait = 0; m_started = 0;
            pbeat[1] = 0; pbeat[2] = 0;
        end else if (o == 0) begin
            m_wait = 0; m_started = 0;
            if (req[1] && req[2]) m_owner = (m_last == 1) ? 2 : 1;
            else if (req[1])      m_owner = 1;
            else if (req[2])      m_owner = 2;
        end else begin
            bit done;
            done = 0;
            if (exp_acc) begin
                m_started = 1;
                pbeat[o]++;
                if (tlast[o] || dsc[o]) begin
                    done = 1;
                    n_pkts_done++;
                end
            end else if (!m_started) begin
                m_wait++;
                if (m_wait == TO) begin
                    done = 1;
                    n_timeouts++;
                end
            end
            if (done) begin
                m_last  = o;
                m_owner = 0;
                pend[o] = 1'b0;
            end
        end
    endtask

    initial begin
        m_owner = 0; m_last = 2; m_wait = 0; m_started = 0;
        pid[1] = 0; pid[2] = 0;
        new_pkt(1);
        new_pkt(2);
        drive();
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
            cyc++;
            drive();
        end
        if (n_pkts_done < 50) begin
            n_cmp++; n_bad++;
            $display("FAIL pkt_count: got %0d required >= 50", n_pkts_done);
        end
        if (n_timeouts < 5) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_count: got %0d required >= 5", n_timeouts);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
